// File: rtl/multiport_memory.sv
// multiport_memory: parametrised N-read / N-write word memory.
// Contents are set by an internal sweep that writes FILL_VALUE to one entry
// per cycle after reset or after an accepted clear; `ready` is high once the
// sweep has covered every entry. Reads are combinational (READ_LATENCY=0)
// or registered read-first (READ_LATENCY=1).
//
// Handshake: there is no back-pressure. A read result is usable when the
// matching r_valid bit is high; a write is taken on any rising edge where
// w_en is high, the FSM is READY and the address is below N_ELEMENTS.
module multiport_memory #(
    parameter int                  N_ELEMENTS   = 128,
    parameter int                  ADDR_WIDTH   = 16,
    parameter int                  DATA_WIDTH   = 16,
    parameter int                  N_READ       = 2,
    parameter int                  N_WRITE      = 1,
    parameter int                  READ_LATENCY = 0,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    output logic                             ready,
    input  logic [N_READ-1:0]                r_en,
    input  logic [N_READ*ADDR_WIDTH-1:0]     r_addr,
    output logic [N_READ*DATA_WIDTH-1:0]     r_data,
    output logic [N_READ-1:0]                r_valid,
    input  logic [N_WRITE-1:0]               w_en,
    input  logic [N_WRITE*ADDR_WIDTH-1:0]    w_addr,
    input  logic [N_WRITE*DATA_WIDTH-1:0]    w_data
);

    localparam int CW = (N_ELEMENTS > 1) ? $clog2(N_ELEMENTS) : 1;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // state is kept as a named signal so checkers can bind to it directly
    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   counter;
    logic            sweep_done;
    logic            clear_accept;

    logic [DATA_WIDTH-1:0] mem [N_ELEMENTS];

    // Address decode helpers: range check on the full address, index on CW bits
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 64'(a) < 64'(N_ELEMENTS);
    endfunction

    function automatic logic [CW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return CW'(a);
    endfunction

    assign sweep_done   = (counter == CW'(N_ELEMENTS - 1));
    assign clear_accept = (state == READY) && clear;

    // State register and sweep counter; counter idles at 0 outside INIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            counter <= '0;
        end else begin
            state <= state_next;
            if (state == INIT && !sweep_done)
                counter <= counter + 1'b1;
            else
                counter <= '0;
        end
    end

    // Next-state: finish the sweep, or restart it on an accepted clear
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (sweep_done) state_next = READY;
            READY:   if (clear)      state_next = INIT;
            default: state_next = INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = (state == READY);
    end

    // Array update: sweep fill in INIT, port writes in READY (later port wins)
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[counter] <= FILL_VALUE;
        end else begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (w_en[p] && in_range(w_addr[p*ADDR_WIDTH +: ADDR_WIDTH]))
                    mem[idx(w_addr[p*ADDR_WIDTH +: ADDR_WIDTH])] <=
                        w_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            // r_en only matters for registered reads
            logic unused_r_en;
            assign unused_r_en = ^r_en;

            // Combinational read of pre-edge contents; zero while INIT or out of range
            always_comb begin
                r_data = '0;
                for (int k = 0; k < N_READ; k++) begin
                    if (ready && in_range(r_addr[k*ADDR_WIDTH +: ADDR_WIDTH]))
                        r_data[k*DATA_WIDTH +: DATA_WIDTH] =
                            mem[idx(r_addr[k*ADDR_WIDTH +: ADDR_WIDTH])];
                end
                r_valid = {N_READ{ready}};
            end
        end else begin : g_reg_read
            // Registered read-first: captures the array before this edge's writes
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data  <= '0;
                    r_valid <= '0;
                end else begin
                    for (int k = 0; k < N_READ; k++) begin
                        if (r_en[k]) begin
                            if (state == READY && in_range(r_addr[k*ADDR_WIDTH +: ADDR_WIDTH]))
                                r_data[k*DATA_WIDTH +: DATA_WIDTH] <=
                                    mem[idx(r_addr[k*ADDR_WIDTH +: ADDR_WIDTH])];
                            else
                                r_data[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        end
                    end
                    r_valid <= r_en & {N_READ{(state == READY) && !clear_accept}};
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_multiport_memory.sv
// Directed bench: instance a (8 words, comb reads, fill A5A5) and
// instance b (128 words, registered reads, fill 5A5A), both with 2 write ports.
module tb_multiport_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_clear = 1'b0;
    logic        a_ready;
    logic [1:0]  a_r_en = '0;
    logic [31:0] a_r_addr = '0;
    logic [31:0] a_r_data;
    logic [1:0]  a_r_valid;
    logic [1:0]  a_w_en = '0;
    logic [31:0] a_w_addr = '0;
    logic [31:0] a_w_data = '0;

    logic        b_clear = 1'b0;
    logic        b_ready;
    logic [1:0]  b_r_en = '0;
    logic [31:0] b_r_addr = '0;
    logic [31:0] b_r_data;
    logic [1:0]  b_r_valid;
    logic [1:0]  b_w_en = '0;
    logic [31:0] b_w_addr = '0;
    logic [31:0] b_w_data = '0;

    int vectors = 0;
    int miscompares = 0;

    multiport_memory #(
        .N_ELEMENTS(8), .ADDR_WIDTH(16), .DATA_WIDTH(16), .N_READ(2),
        .N_WRITE(2), .READ_LATENCY(0), .FILL_VALUE(16'hA5A5)
    ) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear), .ready(a_ready),
        .r_en(a_r_en), .r_addr(a_r_addr), .r_data(a_r_data), .r_valid(a_r_valid),
        .w_en(a_w_en), .w_addr(a_w_addr), .w_data(a_w_data)
    );

    multiport_memory #(
        .N_ELEMENTS(128), .ADDR_WIDTH(16), .DATA_WIDTH(16), .N_READ(2),
        .N_WRITE(2), .READ_LATENCY(1), .FILL_VALUE(16'h5A5A)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear), .ready(b_ready),
        .r_en(b_r_en), .r_addr(b_r_addr), .r_data(b_r_data), .r_valid(b_r_valid),
        .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_a_valid", 32'(a_r_valid), 32'd0);
        check("rst_b_valid", 32'(b_r_valid), 32'd0);
        check("rst_b_data", b_r_data, 32'd0);

        // Init sweep; a write to a's addr 0 is held throughout and must be ignored
        a_w_en = 2'b01; a_w_addr = {16'd0, 16'd0}; a_w_data = {16'h0, 16'hDEAD};
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            step();
            check("sweep_a_ready", 32'(a_ready), 32'(i >= 8));
            check("sweep_b_ready", 32'(b_ready), 32'(i >= 128));
            if (i == 8) a_w_en = 2'b00;
        end

        // All entries of a read the fill value on both ports
        for (int i = 0; i < 8; i++) begin
            a_r_addr = {16'(7 - i), 16'(i)};
            #1;
            check("fill_a_p0", {16'h0, a_r_data[15:0]}, 32'h0000A5A5);
            check("fill_a_p1", {16'h0, a_r_data[31:16]}, 32'h0000A5A5);
        end
        check("a_valid_ready", 32'(a_r_valid), 32'd3);

        // Write conflict: both ports to addr 5, port 1 wins; no bypass before edge
        a_w_en = 2'b11; a_w_addr = {16'd5, 16'd5}; a_w_data = {16'h2222, 16'h1111};
        a_r_addr = {16'd5, 16'd5};
        #1;
        check("a_no_bypass", {16'h0, a_r_data[15:0]}, 32'h0000A5A5);
        step();
        a_w_en = 2'b00;
        #1;
        check("a_conflict", a_r_data, 32'h22222222);

        // Independent writes on both ports
        a_w_en = 2'b11; a_w_addr = {16'd6, 16'd1}; a_w_data = {16'h0606, 16'h0101};
        step();
        a_w_en = 2'b00;
        a_r_addr = {16'd6, 16'd1};
        #1;
        check("a_two_writes", a_r_data, 32'h06060101);

        // Out-of-range write dropped (200 mod 8 aliases addr 0); out-of-range read is 0
        a_w_en = 2'b10; a_w_addr = {16'd200, 16'd0}; a_w_data = {16'hFFFF, 16'h0};
        step();
        a_w_en = 2'b00;
        a_r_addr = {16'd0, 16'd200};
        #1;
        check("a_oor_read", a_r_data, 32'hA5A50000);
        check("a_oor_valid", 32'(a_r_valid), 32'd3);

        // Registered read-first on b
        b_w_en = 2'b01; b_w_addr = {16'd0, 16'd3}; b_w_data = {16'h0, 16'h0007};
        step();
        check("b_idle_valid", 32'(b_r_valid), 32'd0);
        b_w_data = {16'h0, 16'h0009};
        b_r_en = 2'b01; b_r_addr = {16'd0, 16'd3};
        step();
        check("b_read_first", {16'h0, b_r_data[15:0]}, 32'h00000007);
        check("b_rf_valid", 32'(b_r_valid), 32'd1);
        b_w_en = 2'b00;
        step();
        check("b_read_new", {16'h0, b_r_data[15:0]}, 32'h00000009);

        // Hold when r_en low
        b_r_en = 2'b00; b_r_addr = {16'd0, 16'd4};
        step();
        check("b_hold_data", {16'h0, b_r_data[15:0]}, 32'h00000009);
        check("b_hold_valid", 32'(b_r_valid), 32'd0);

        // Last entry on port 1, out-of-range on port 0
        b_r_en = 2'b11; b_r_addr = {16'd127, 16'd200};
        step();
        check("b_last_oor", b_r_data, 32'h5A5A0000);
        check("b_both_valid", 32'(b_r_valid), 32'd3);

        // Clear on b: data still captured, valid drops, then zero during INIT
        b_clear = 1'b1;
        step();
        b_clear = 1'b0;
        check("b_clr_ready", 32'(b_ready), 32'd0);
        check("b_clr_valid", 32'(b_r_valid), 32'd0);
        check("b_clr_data", b_r_data, 32'h5A5A0000);
        step();
        check("b_init_data", b_r_data, 32'd0);
        check("b_init_valid", 32'(b_r_valid), 32'd0);
        b_r_en = 2'b00;

        // Clear on a with a same-cycle write; INIT writes and a repeated clear ignored
        a_clear = 1'b1;
        a_w_en = 2'b01; a_w_addr = {16'd0, 16'd2}; a_w_data = {16'h0, 16'h0033};
        step();
        a_clear = 1'b0;
        check("a_clr_ready", 32'(a_ready), 32'd0);
        check("a_clr_valid", 32'(a_r_valid), 32'd0);
        a_r_addr = {16'd5, 16'd6};
        #1;
        check("a_init_data", a_r_data, 32'd0);
        a_w_en = 2'b01; a_w_addr = {16'd0, 16'd0}; a_w_data = {16'h0, 16'hBEEF};
        for (int i = 1; i <= 8; i++) begin
            a_clear = (i == 3);
            step();
            check("a_resweep_ready", 32'(a_ready), 32'(i >= 8));
        end
        a_clear = 1'b0;
        a_w_en = 2'b00;
        a_r_addr = {16'd0, 16'd2};
        #1;
        check("a_resweep_2_0", a_r_data, 32'hA5A5A5A5);
        a_r_addr = {16'd6, 16'd5};
        #1;
        check("a_resweep_6_5", a_r_data, 32'hA5A5A5A5);

        // Reset mid-sweep on a at counter 4
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        for (int i = 0; i < 4; i++) step();
        b_r_en = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_a_ready", 32'(a_ready), 32'd0);
        check("mid_rst_a_valid", 32'(a_r_valid), 32'd0);
        check("mid_rst_b_valid", 32'(b_r_valid), 32'd0);
        check("mid_rst_b_data", b_r_data, 32'd0);
        #1;
        rst = 1'b0;
        b_r_en = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("restart_a_ready", 32'(a_ready), 32'(i >= 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
